// File: rtl/load_store_unit.sv
// Load/store stage: one req/ack memory access at a time, with byte-lane steering and load extension.
// Define MISALIGN_TRAP_EN to fault misaligned half/word accesses instead of forcing alignment.
module load_store_unit #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        busy,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    localparam int unsigned CW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          we_q, we_d;
    logic [1:0]    size_q, size_d;
    logic          uns_q, uns_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q, err_d;

    logic          req_fault;
    logic          tmo_hit;
    logic [3:0]    be;
    logic [31:0]   st_data;
    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;
    logic [31:0]   ld_data;

    always_comb begin
        req_fault = (req_size == 2'b11);
`ifdef MISALIGN_TRAP_EN
        if (req_size == 2'b01 && req_addr[0])
            req_fault = 1'b1;
        if (req_size == 2'b10 && req_addr[1:0] != 2'b00)
            req_fault = 1'b1;
`endif
    end

    assign tmo_hit = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1));

    // Half lanes use only addr[1] and word access ignores addr[1:0], which
    // is what forces misaligned accesses to alignment when not trapping.
    always_comb begin
        case (size_q)
            2'b00:   be = 4'b0001 << addr_q[1:0];
            2'b01:   be = addr_q[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
    end

    always_comb begin
        case (size_q)
            2'b00:   st_data = {4{wdata_q[7:0]}};
            2'b01:   st_data = {2{wdata_q[15:0]}};
            default: st_data = wdata_q;
        endcase
    end

    always_comb begin
        case (addr_q[1:0])
            2'b00:   ld_byte = mem_rdata[7:0];
            2'b01:   ld_byte = mem_rdata[15:8];
            2'b10:   ld_byte = mem_rdata[23:16];
            default: ld_byte = mem_rdata[31:24];
        endcase
        ld_half = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (size_q)
            2'b00:   ld_data = uns_q ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            2'b01:   ld_data = uns_q ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
            default: ld_data = mem_rdata;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        size_d  = size_q;
        uns_d   = uns_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    cnt_d   = '0;
                    rdata_d = '0;
                    if (req_fault) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else begin
                        err_d   = 1'b0;
                        state_d = ACCESS;
                    end
                end
            end
            ACCESS: begin
                if (mem_ack) begin
                    rdata_d = we_q ? '0 : ld_data;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (tmo_hit) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Outputs decode straight from state so an async reset drops them at once.
    assign req_ready  = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = resp_valid ? rdata_q : '0;
    assign resp_err   = resp_valid & err_q;
    assign mem_req    = (state_q == ACCESS);
    assign mem_we     = mem_req & we_q;
    assign mem_addr   = mem_req ? {addr_q[31:2], 2'b00} : '0;
    assign mem_be     = mem_req ? be : '0;
    assign mem_wdata  = mem_req ? st_data : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: stimulus pushes expected responses, a monitor pops and checks them.
module tb_load_store_unit;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        busy;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int tests = 0;
    int fails = 0;
    logic [32:0] exp_q[$];

    load_store_unit #(.TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .busy(busy), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: any resp_valid pops one expected {err, rdata} entry.
    initial begin
        forever begin
            @(negedge clk);
            if (resp_valid === 1'b1) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_resp: got rdata 0x%08h err %0b, expected no response",
                             resp_rdata, resp_err);
                end else begin
                    logic [32:0] e;
                    e = exp_q.pop_front();
                    if (resp_rdata !== e[31:0] || resp_err !== e[32]) begin
                        fails++;
                        $display("FAIL resp: got rdata 0x%08h err %0b expected rdata 0x%08h err %0b",
                                 resp_rdata, resp_err, e[31:0], e[32]);
                    end
                end
            end
        end
    end

    // ack_dly: cycles of mem_req before mem_ack (-1 = never).
    task automatic run(input string name, input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] mrdata,
                       input int ack_dly, input logic exp_mem, input logic [31:0] exp_addr,
                       input logic [3:0] exp_be, input logic [31:0] exp_wd, input int exp_cycles,
                       input logic [31:0] exp_rd, input logic exp_err);
        int cyc;
        @(negedge clk);
        check({name, "/ready"}, {31'h0, req_ready}, 32'h1);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        exp_q.push_back({exp_err, exp_rd});
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_wdata = 32'h0;
        cyc = 0;
        if (exp_mem) begin
            while (mem_req === 1'b1 && cyc < 40) begin
                check({name, "/mem_we"}, {31'h0, mem_we}, {31'h0, we});
                check({name, "/mem_addr"}, mem_addr, exp_addr);
                check({name, "/mem_be"}, {28'h0, mem_be}, {28'h0, exp_be});
                check({name, "/mem_wdata"}, mem_wdata, exp_wd);
                if (cyc == ack_dly) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mrdata;
                end
                @(posedge clk);
                #1;
                mem_ack   = 1'b0;
                mem_rdata = 32'h0;
                cyc++;
            end
            check({name, "/req_cycles"}, cyc, exp_cycles);
        end else begin
            check({name, "/no_mem_req"}, {31'h0, mem_req}, 32'h0);
        end
        check({name, "/resp_timing"}, {31'h0, resp_valid}, 32'h1);
        @(posedge clk);
        #1;
        check({name, "/ready_after"}, {31'h0, req_ready}, 32'h1);
        check({name, "/resp_pulse"}, {31'h0, resp_valid}, 32'h0);
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;
        #12;
        check("rst/ready", {31'h0, req_ready}, 32'h1);
        check("rst/busy", {31'h0, busy}, 32'h0);
        check("rst/mem_req", {31'h0, mem_req}, 32'h0);
        check("rst/resp_valid", {31'h0, resp_valid}, 32'h0);
        check("rst/mem_be", {28'h0, mem_be}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        run("lw", 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 0, 1'b1,
            32'h100, 4'b1111, 32'h0, 1, 32'hDEADBEEF, 1'b0);
        run("lb", 1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 32'h80123456, 0, 1'b1,
            32'h100, 4'b1000, 32'h0, 1, 32'hFFFFFF80, 1'b0);
        run("lbu", 1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 32'h80123456, 1, 1'b1,
            32'h100, 4'b1000, 32'h0, 2, 32'h00000080, 1'b0);
        run("sh", 1'b1, 2'b01, 1'b0, 32'h202, 32'h1234ABCD, 32'hFFFFFFFF, 3, 1'b1,
            32'h200, 4'b1100, 32'hABCDABCD, 4, 32'h0, 1'b0);
        run("sb", 1'b1, 2'b00, 1'b0, 32'h201, 32'h00000055, 32'h0, 0, 1'b1,
            32'h200, 4'b0010, 32'h55555555, 1, 32'h0, 1'b0);
        run("lh", 1'b0, 2'b01, 1'b0, 32'h102, 32'h0, 32'h80017FFF, 2, 1'b1,
            32'h100, 4'b1100, 32'h0, 3, 32'hFFFF8001, 1'b0);
        run("lhu", 1'b0, 2'b01, 1'b1, 32'h100, 32'h0, 32'h80018765, 0, 1'b1,
            32'h100, 4'b0011, 32'h0, 1, 32'h00008765, 1'b0);
        run("size11", 1'b0, 2'b11, 1'b0, 32'h100, 32'h0, 32'h0, -1, 1'b0,
            32'h0, 4'b0, 32'h0, 0, 32'h0, 1'b1);
`ifdef MISALIGN_TRAP_EN
        run("lw_mis", 1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 32'hCAFEF00D, 0, 1'b0,
            32'h0, 4'b0, 32'h0, 0, 32'h0, 1'b1);
`else
        run("lw_mis", 1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 32'hCAFEF00D, 0, 1'b1,
            32'h100, 4'b1111, 32'h0, 1, 32'hCAFEF00D, 1'b0);
`endif
        run("timeout", 1'b0, 2'b10, 1'b0, 32'h400, 32'h0, 32'h0, -1, 1'b1,
            32'h400, 4'b1111, 32'h0, 16, 32'h0, 1'b1);
        run("ack_last", 1'b0, 2'b10, 1'b0, 32'h404, 32'h0, 32'h13579BDF, 15, 1'b1,
            32'h404, 4'b1111, 32'h0, 16, 32'h13579BDF, 1'b0);

        // Reset during ACCESS: no response may follow.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = 32'h300;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_abort/mem_req_before", {31'h0, mem_req}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_abort/mem_req", {31'h0, mem_req}, 32'h0);
        check("rst_abort/busy", {31'h0, busy}, 32'h0);
        check("rst_abort/ready", {31'h0, req_ready}, 32'h1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_abort/no_resp", {31'h0, resp_valid}, 32'h0);
        run("lw_after_rst", 1'b0, 2'b10, 1'b0, 32'h308, 32'h0, 32'h2468ACE0, 1, 1'b1,
            32'h308, 4'b1111, 32'h0, 2, 32'h2468ACE0, 1'b0);

        repeat (3) @(posedge clk);
        check("scoreboard_empty", exp_q.size(), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Data-memory access stage directly downstream of the ALU in the RISC-V datapath.
- Takes the ALU result as the effective address and rs2 as store data, and runs one memory transaction at a time over a req/ack memory port.
- Returns sign- or zero-extended load data for writeback, and asserts busy so the core stalls while an access is outstanding.

Parameters:
- TIMEOUT, 16, cycles to wait for mem_ack before the access is aborted with an error; 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  access request from the execute stage.
- req_ready  out  1  unit can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
- req_unsigned  in  1  load zero-extends (LBU/LHU) when 1.
- req_addr  in  32  effective address (ALUout).
- req_wdata  in  32  store data (rs2).
- resp_valid  out  1  one-cycle pulse: access complete.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  qualifies resp_valid: access faulted.
- busy  out  1  high whenever state is not IDLE; stalls the PC.
- mem_req  out  1  memory request.
- mem_we  out  1  memory write enable.
- mem_addr  out  32  word-aligned address, {req_addr[31:2],2'b00}.
- mem_be  out  4  byte enables.
- mem_wdata  out  32  lane-replicated store data.
- mem_ack  in  1  memory completed the access this cycle.
- mem_rdata  in  32  read word, valid while mem_ack is high.

Behaviour:
- FSM states: IDLE, ACCESS, RESP.
- Reset (async, rst_n low):
  - State goes to IDLE and the timeout counter clears.
  - All outputs are 0 except req_ready, which is 1.
  - A transaction in flight is abandoned: mem_req drops immediately and no response is produced.
- IDLE:
  - req_ready=1, busy=0.
  - On req_valid at a clock edge, latch we/size/unsigned/addr/wdata.
  - Go to ACCESS, unless the request is faulting (see Optional Feature, or req_size=11). A faulting request goes straight to RESP with the error flag set.
- ACCESS:
  - mem_req=1, and mem_we/mem_addr/mem_be/mem_wdata are held stable until mem_ack.
  - The counter increments every cycle without ack.
  - On mem_ack: capture and extract the load data, then go to RESP with err=0.
  - If TIMEOUT!=0 and the counter reaches TIMEOUT-1 without ack: go to RESP with err=1.
  - If ack and the timeout terminal count occur in the same cycle, ack wins.
- RESP:
  - resp_valid=1 for exactly one cycle; resp_err and resp_rdata are registered and valid in that cycle.
  - Then return to IDLE. There is no backpressure on resp.
- Latency:
  - Request accepted at edge N; mem_req is high from cycle N+1.
  - An ack k cycles later (k>=0) gives resp_valid in cycle N+2+k.
  - Minimum request-to-response is 2 cycles; back-to-back throughput is one access per 3 cycles.
- mem_ack outside ACCESS is ignored.
- Byte enables:
  - byte: 4'b0001 << addr[1:0].
  - half: 4'b0011 << {addr[1],1'b0}.
  - word: 4'b1111.
  - Loads drive the same enables as stores.
- Store data: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word wdata.
- Load extraction:
  - byte: select lane addr[1:0]; half: select lane addr[1].
  - Sign-extend from bit 7 or bit 15, or zero-extend when req_unsigned=1. Word loads pass through.
- Counter width is $clog2(TIMEOUT+1). The counter clears on entry to ACCESS.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined:
  - A half access with addr[0]=1, or a word access with addr[1:0]!=0, is faulting.
  - No memory request is issued; the unit goes IDLE->RESP with resp_err=1 and resp_rdata=0.
- Undefined:
  - Misaligned addresses are forced to alignment (half clears bit 0; word clears bits 1:0) before lane selection.
  - The access proceeds normally with err=0.
- req_size=11 always faults, with or without the macro.

Test Plan:
- Word load at addr 0x0000_0100, mem_rdata=0xDEADBEEF, ack 0 cycles after mem_req -> mem_addr=0x100, mem_be=1111; resp_valid 2 cycles after accept with rdata=0xDEADBEEF, err=0.
- Byte load, signed, addr 0x103, mem_rdata=0x80123456 -> mem_be=1000, rdata=0xFFFFFF80. Same access with req_unsigned=1 -> 0x00000080.
- Store half, addr 0x202, wdata=0x1234ABCD, ack after 3 cycles -> mem_we=1, mem_be=1100, mem_wdata=0xABCDABCD held 4 cycles; resp rdata=0, err=0.
- Word load at 0x101 -> with MISALIGN_TRAP_EN: no mem_req, resp_err=1 one cycle after accept. Without the macro: mem_addr=0x100, err=0.
- TIMEOUT=16, mem_ack never asserted -> mem_req high exactly 16 cycles, then resp_valid with err=1, then req_ready=1. A second run with ack on the 16th cycle -> err=0.
- rst_n pulled low while in ACCESS -> mem_req and busy drop asynchronously and no resp_valid appears. After release, req_ready=1, and a new word load completes normally.
